// File: rtl/core_test_sequencer.sv
// Run-control and self-check block for the core under test: sequences the core reset, snoops tohost writes,
// runs a watchdog and reports PASS/FAIL/TIMEOUT. Optional hang detector enabled by `define CORE_HANG_DET_EN.
module core_test_sequencer #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                CNT_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int                RST_CYCLES     = 4,
    parameter int                TIMEOUT_CYCLES = 10000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              DMEM_WE,
    input  logic [ADDR_W-1:0] DMEM_ADDR,
    input  logic [DATA_W-1:0] DMEM_WDATA,
    input  logic [ADDR_W-1:0] PC,
    output logic              CORE_RST,
    output logic              RUNNING,
    output logic              DONE,
    output logic              PASS,
    output logic              TIMEOUT,
`ifdef CORE_HANG_DET_EN
    output logic              HANG,
`endif
    output logic [DATA_W-1:0] FAIL_CODE,
    output logic [CNT_W-1:0]  CYCLE_COUNT,
    output logic [ADDR_W-1:0] LAST_PC
);

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        RUN,
        S_PASS,
        S_FAIL,
        S_TOUT
    } state_t;

    localparam logic [7:0]        RST_LAST   = 8'(RST_CYCLES - 1);
    localparam bit                TOUT_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]  TOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] WDATA_PASS = DATA_W'(1);

    state_t           state;
    logic [7:0]       rst_cnt;
    logic             tohost_hit;
    logic             tout_hit;
    logic             hang_hit;
    logic             can_start;
    logic [CNT_W-1:0] cnt_next;

    // A write of zero to tohost is not a verdict, so it never counts as a hit.
    assign tohost_hit = DMEM_WE && (DMEM_ADDR == TOHOST_ADDR) && (DMEM_WDATA != '0);
    assign tout_hit   = TOUT_EN && (CYCLE_COUNT == TOUT_LAST);
    assign cnt_next   = (&CYCLE_COUNT) ? CYCLE_COUNT : CYCLE_COUNT + CNT_W'(1);
    assign can_start  = (state == IDLE) || (state == S_PASS) || (state == S_FAIL) || (state == S_TOUT);

`ifdef CORE_HANG_DET_EN
    localparam int               HANG_CYCLES = 64;
    localparam int               HANG_W      = $clog2(HANG_CYCLES);
    localparam logic [HANG_W-1:0] HANG_LAST  = HANG_W'(HANG_CYCLES - 1);

    logic [HANG_W-1:0] hang_cnt;
    logic [ADDR_W-1:0] prev_pc;
    logic              pc_stalled;

    assign pc_stalled = (PC == prev_pc) && !DMEM_WE;
    assign hang_hit   = (state == RUN) && pc_stalled && (hang_cnt == HANG_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hang_cnt <= '0;
            prev_pc  <= '0;
            HANG     <= 1'b0;
        end else begin
            prev_pc <= PC;
            if (state != RUN || !pc_stalled)
                hang_cnt <= '0;
            else if (!hang_hit)
                hang_cnt <= hang_cnt + HANG_W'(1);

            if (START && can_start)
                HANG <= 1'b0;
            else if (hang_hit && !tohost_hit)
                HANG <= 1'b1;
        end
    end
`else
    assign hang_hit = 1'b0;
`endif

    // NOTE: all state and outputs are registered with non-blocking assignments so every flop
    // samples the pre-edge values; the reset branch is inside the clocked block because it is synchronous.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            CORE_RST    <= 1'b1;
            RUNNING     <= 1'b0;
            DONE        <= 1'b0;
            PASS        <= 1'b0;
            TIMEOUT     <= 1'b0;
            FAIL_CODE   <= '0;
            CYCLE_COUNT <= '0;
            LAST_PC     <= '0;
        end else begin
            case (state)
                IDLE, S_PASS, S_FAIL, S_TOUT: begin
                    CORE_RST <= 1'b1;
                    if (START) begin
                        state       <= CRST;
                        rst_cnt     <= '0;
                        DONE        <= 1'b0;
                        PASS        <= 1'b0;
                        TIMEOUT     <= 1'b0;
                        FAIL_CODE   <= '0;
                        CYCLE_COUNT <= '0;
                        LAST_PC     <= '0;
                    end
                end

                CRST: begin
                    if (rst_cnt == RST_LAST) begin
                        state    <= RUN;
                        CORE_RST <= 1'b0;
                        RUNNING  <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end

                RUN: begin
                    CYCLE_COUNT <= cnt_next;
                    if (tohost_hit || tout_hit || hang_hit) begin
                        RUNNING  <= 1'b0;
                        CORE_RST <= 1'b1;
                        DONE     <= 1'b1;
                        LAST_PC  <= PC;
                        // A verdict written on the same cycle as a timeout or hang takes priority.
                        if (tohost_hit) begin
                            if (DMEM_WDATA == WDATA_PASS) begin
                                state <= S_PASS;
                                PASS  <= 1'b1;
                            end else begin
                                state     <= S_FAIL;
                                FAIL_CODE <= DMEM_WDATA >> 1;
                            end
                        end else begin
                            state   <= S_TOUT;
                            TIMEOUT <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_test_sequencer.sv
// Scoreboard bench for core_test_sequencer: stimulus pushes expected verdicts, a monitor pops them on DONE.
module tb_core_test_sequencer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [ADDR_W-1:0] pc;
    logic              core_rst;
    logic              running;
    logic              done;
    logic              pass;
    logic              timeout;
`ifdef CORE_HANG_DET_EN
    logic              hang;
`endif
    logic [DATA_W-1:0] fail_code;
    logic [CNT_W-1:0]  cycle_count;
    logic [ADDR_W-1:0] last_pc;

    always #5 clk = ~clk;

    core_test_sequencer #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .CNT_W         (CNT_W),
        .TOHOST_ADDR   (32'h0000_1000),
        .RST_CYCLES    (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK        (clk),
        .RESET      (reset),
        .START      (start),
        .DMEM_WE    (dmem_we),
        .DMEM_ADDR  (dmem_addr),
        .DMEM_WDATA (dmem_wdata),
        .PC         (pc),
        .CORE_RST   (core_rst),
        .RUNNING    (running),
        .DONE       (done),
        .PASS       (pass),
        .TIMEOUT    (timeout),
`ifdef CORE_HANG_DET_EN
        .HANG       (hang),
`endif
        .FAIL_CODE  (fail_code),
        .CYCLE_COUNT(cycle_count),
        .LAST_PC    (last_pc)
    );

    typedef struct {
        logic        pass;
        logic        tout;
        logic        hang;
        logic [31:0] fail_code;
        logic [31:0] count;
        logic [31:0] last_pc;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   run_cyc  = 0;
    bit   mon_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One RUN cycle: PC advances by 4 so the displayed count k always pairs with pc = base + 4k.
    task automatic run_step();
        step();
        pc = pc + 32'd4;
        run_cyc++;
    endtask

    task automatic hit(input logic [31:0] addr, input logic [31:0] wdata);
        dmem_we    = 1'b1;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        run_step();
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_core_rst"}, core_rst, 1);
        check({tag, "_running"}, running, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_fail_code"}, fail_code, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_last_pc"}, last_pc, 0);
`ifdef CORE_HANG_DET_EN
        check({tag, "_hang"}, hang, 0);
`endif
    endtask

    task automatic start_run(input string tag, input logic [31:0] base);
        int n;
        n     = 0;
        pc    = base;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && !running; i++) begin
            if (core_rst) n++;
            step();
        end
        check({tag, "_crst_len"}, n, 4);
        check({tag, "_running"}, running, 1);
        check({tag, "_core_rst_low"}, core_rst, 0);
        check({tag, "_count_start"}, cycle_count, 0);
`ifdef CORE_HANG_DET_EN
        check({tag, "_hang_clear"}, hang, 0);
`endif
        run_cyc = 0;
    endtask

    // Monitor: every rising DONE must match the oldest expected verdict.
    initial begin
        forever begin
            @(negedge clk);
            if (done && !mon_seen) begin
                mon_seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("res_pass", pass, e.pass);
                    check("res_timeout", timeout, e.tout);
                    check("res_fail_code", fail_code, e.fail_code);
                    check("res_cycle_count", cycle_count, e.count);
                    check("res_last_pc", last_pc, e.last_pc);
                    check("res_running", running, 0);
                    check("res_core_rst", core_rst, 1);
`ifdef CORE_HANG_DET_EN
                    check("res_hang", hang, e.hang);
`endif
                end
            end else if (!done) begin
                mon_seen = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        pc         = '0;
        step();
        step();
        check_reset_state("por");
        reset = 1'b0;
        step();
        check("idle_core_rst", core_rst, 1);

        // PASS at count 37, with a START pulse during RUN that must be ignored.
        start_run("t1", 32'h8000_0000);
        repeat (20) run_step();
        start = 1'b1;
        run_step();
        start = 1'b0;
        check("start_in_run_ignored", {running, core_rst}, 2'b10);
        check("start_in_run_count", cycle_count, 21);
        repeat (16) run_step();
        check("t1_count_37", cycle_count, 37);
        sb.push_back('{pass: 1'b1, tout: 1'b0, hang: 1'b0, fail_code: 32'd0, count: 32'd38, last_pc: pc});
        hit(32'h0000_1000, 32'd1);
        check("t1_done_next_cycle", done, 1);
        step();
        check("t1_result_held", {done, pass}, 2'b11);

        // FAIL with code 0xB >> 1; non-tohost, zero and unqualified writes are ignored.
        start_run("t2", 32'h8000_1000);
        repeat (5) run_step();
        hit(32'h0000_1004, 32'h0000_000B);
        check("ignore_other_addr", {done, running}, 2'b01);
        hit(32'h0000_1000, 32'h0000_0000);
        check("ignore_zero_wdata", {done, running}, 2'b01);
        dmem_addr  = 32'h0000_1000;
        dmem_wdata = 32'h0000_000B;
        run_step();
        dmem_addr  = '0;
        dmem_wdata = '0;
        check("ignore_no_we", {done, running}, 2'b01);
        check("t2_count_model", cycle_count, run_cyc);
        sb.push_back('{pass: 1'b0, tout: 1'b0, hang: 1'b0, fail_code: 32'd5,
                       count: run_cyc + 1, last_pc: pc});
        hit(32'h0000_1000, 32'h0000_000B);
        check("t2_pass_low", {done, pass}, 2'b10);

        // Watchdog expires after 100 RUN cycles.
        start_run("t3", 32'h8000_2000);
        sb.push_back('{pass: 1'b0, tout: 1'b1, hang: 1'b0, fail_code: 32'd0, count: 32'd100,
                       last_pc: 32'h8000_2000 + 32'd396});
        for (int i = 0; i < 150 && !done; i++) run_step();
        check("t3_timeout_reached", {done, timeout}, 2'b11);

        // Hit on the final watchdog cycle: the verdict wins.
        start_run("t4", 32'h8000_3000);
        repeat (99) run_step();
        check("t4_count_99", cycle_count, 99);
        sb.push_back('{pass: 1'b1, tout: 1'b0, hang: 1'b0, fail_code: 32'd0, count: 32'd100, last_pc: pc});
        hit(32'h0000_1000, 32'd1);
        check("t4_no_timeout", {pass, timeout}, 2'b10);

        // RESET on the 10th RUN cycle aborts; the rerun restarts the count from zero.
        start_run("t5", 32'h8000_4000);
        repeat (9) run_step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("midrun");
        start_run("t5b", 32'h8000_5000);
        repeat (3) run_step();
        sb.push_back('{pass: 1'b1, tout: 1'b0, hang: 1'b0, fail_code: 32'd0, count: 32'd4, last_pc: pc});
        hit(32'h0000_1000, 32'd1);

`ifdef CORE_HANG_DET_EN
        // Self-loop PC with no writes trips the hang detector after 64 RUN cycles.
        start_run("t6", 32'h0000_0080);
        sb.push_back('{pass: 1'b0, tout: 1'b1, hang: 1'b1, fail_code: 32'd0, count: 32'd64,
                       last_pc: 32'h0000_0080});
        for (int i = 0; i < 100 && !done; i++) step();
        check("t6_hang_reached", {done, timeout, hang}, 3'b111);
`endif

        step();
        step();
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_test_sequencer.md
Name: core_test_sequencer

Overview:
- Synthesizable run-control and self-check block that sits between the system interface and the RISC-V core under test (Fase 3 onward).
- Generates the core reset sequence and starts execution.
- Snoops the core data-memory write bus for a "tohost" signature write, counts cycles, enforces a watchdog, and reports PASS/FAIL/TIMEOUT.
- Parametrised in bus width, signature address, reset length and timeout, so the same block serves every test program without bench edits.

Parameters:
- ADDR_W, 32, width of PC and data-memory address.
- DATA_W, 32, width of data-memory write data and FAIL_CODE.
- CNT_W, 32, width of cycle counter.
- TOHOST_ADDR, 32'h0000_1000, data-memory address whose write ends the test.
- RST_CYCLES, 4, cycles CORE_RST is held high; legal range 1..255.
- TIMEOUT_CYCLES, 10000, run cycles before TIMEOUT; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous active-high reset of this block.
- START  in  1  single-cycle pulse; begins a run from IDLE or any final state.
- DMEM_WE  in  1  core data-memory write enable (snooped).
- DMEM_ADDR  in  ADDR_W  core data-memory address (snooped).
- DMEM_WDATA  in  DATA_W  core data-memory write data (snooped).
- PC  in  ADDR_W  core program counter (snooped).
- CORE_RST  out  1  active-high reset to the core.
- RUNNING  out  1  high while in RUN.
- DONE  out  1  high in PASS, FAIL or TIMEOUT.
- PASS  out  1  high only in PASS.
- TIMEOUT  out  1  high only in TIMEOUT.
- FAIL_CODE  out  DATA_W  failing test number; 0 unless in FAIL.
- CYCLE_COUNT  out  CNT_W  RUN cycles elapsed; frozen once DONE.
- LAST_PC  out  ADDR_W  PC sampled on the cycle the run ended.

Behaviour:
- Reset: one clock, CLK; reset RESET is synchronous and active-high.
- While RESET is high at a clock edge, the next state is IDLE and outputs are CORE_RST=1, RUNNING=0, DONE=0, PASS=0, TIMEOUT=0, FAIL_CODE=0, CYCLE_COUNT=0, LAST_PC=0.
- RESET mid-run aborts the run immediately; no result is latched.
- FSM states: IDLE, CRST, RUN, S_PASS, S_FAIL, S_TOUT.
- IDLE: CORE_RST=1. START moves to CRST next cycle and clears CYCLE_COUNT, FAIL_CODE and LAST_PC.
- CRST: CORE_RST=1 for exactly RST_CYCLES cycles, timed by an internal 8-bit counter. Then RUN, with CORE_RST=0 from the first RUN cycle.
- RUN:
  - CYCLE_COUNT increments every cycle. It saturates at all-ones and does not wrap.
  - A tohost hit is DMEM_WE=1 and DMEM_ADDR==TOHOST_ADDR on the same cycle.
  - Hit with WDATA==1 -> S_PASS.
  - Hit with WDATA!=1 and WDATA!=0 -> S_FAIL, FAIL_CODE=WDATA>>1.
  - Hit with WDATA==0 is ignored.
  - TIMEOUT_CYCLES!=0 and CYCLE_COUNT==TIMEOUT_CYCLES-1 with no hit -> S_TOUT.
  - Hit and timeout on the same cycle: the hit wins.
  - On the exit edge, LAST_PC<=PC and CYCLE_COUNT takes its final increment.
  - Latency: a hit at cycle N gives DONE=1 at cycle N+1.
- Final states (S_PASS/S_FAIL/S_TOUT):
  - CORE_RST=1 to freeze the core.
  - Results are held until RESET or START.
  - START re-enters CRST, same as from IDLE.
- START in CRST or RUN is ignored.

Optional Feature:
- Macro CORE_HANG_DET_EN.
- When defined:
  - Adds output HANG (1 bit, reset 0) and local parameter HANG_CYCLES = 64.
  - In RUN, a counter tracks consecutive cycles with PC unchanged and no DMEM_WE.
  - Reaching HANG_CYCLES moves to S_TOUT with HANG=1.
  - A tohost hit on that same cycle takes priority.
  - HANG clears on START or RESET.
- When undefined: no HANG port or logic; a self-loop PC is caught only by the watchdog.

Test Plan:
- RESET=1 for 2 cycles, then START -> CORE_RST high exactly 4 cycles after CRST entry, then RUNNING=1.
- In RUN, write DMEM_ADDR=0x1000, WDATA=1 at CYCLE_COUNT=37 -> next cycle DONE=1, PASS=1, CYCLE_COUNT=38, LAST_PC = PC at the hit cycle.
- Write WDATA=0x0000_000B to 0x1000 -> FAIL state, FAIL_CODE=5, PASS=0. Writes to 0x1004 or with WDATA=0 cause no state change.
- TIMEOUT_CYCLES=100, no tohost write -> TIMEOUT=1, DONE=1, CYCLE_COUNT=100. Repeat with a hit on cycle 99 -> PASS wins.
- Assert RESET on the 10th RUN cycle -> IDLE next cycle, all outputs at reset values. START afterwards -> clean rerun with CYCLE_COUNT restarting from 0.
- With CORE_HANG_DET_EN defined: hold PC=0x80 constant, DMEM_WE=0 -> HANG=1 and TIMEOUT=1 after 64 RUN cycles.
